// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width.
package serial_adder_ctrl_pkg;

    localparam int N_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        FINISH = 2'b10
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle of the bit-serial adder.
// master: START, A, B, CIN out; BUSY, DONE, S, COUT in. slave: reverse.
interface serial_adder_ctrl_if
    import serial_adder_ctrl_pkg::*;
#(
    parameter int N = N_DEF
) ();

    logic         START;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         CIN;
    logic         BUSY;
    logic         DONE;
    logic [N-1:0] S;
    logic         COUT;

    modport master (
        output START, A, B, CIN,
        input  BUSY, DONE, S, COUT
    );

    modport slave (
        input  START, A, B, CIN,
        output BUSY, DONE, S, COUT
    );

endinterface

// File: rtl/serial_adder_ctrl_full_adder_bit.sv
// Combinational one-bit full adder shared over all bit positions.
// Ports: A, B, Cin in; S (sum), Cout (majority carry) out.
module full_adder_bit (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: one full-adder cell stepped LSB-first.
// Ports: CLK, RST (sync, active-high); bus (slave) carries request/result.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    serial_adder_ctrl_if.slave bus
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    logic [N-1:0]  reg_a;
    logic [N-1:0]  reg_b;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          fa_sum;
    logic          fa_cout;

    full_adder_bit u_fa (
        .A    (reg_a[0]),
        .B    (reg_b[0]),
        .Cin  (carry),
        .S    (fa_sum),
        .Cout (fa_cout)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            reg_a    <= '0;
            reg_b    <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            bus.S    <= '0;
            bus.COUT <= 1'b0;
            bus.DONE <= 1'b0;
            bus.BUSY <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.START) begin
                        reg_a    <= bus.A;
                        reg_b    <= bus.B;
                        carry    <= bus.CIN;
                        cnt      <= '0;
                        bus.S    <= '0;
                        bus.COUT <= 1'b0;
                        bus.BUSY <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    carry <= fa_cout;
                    bus.S <= {fa_sum, bus.S[N-1:1]};
                    reg_a <= reg_a >> 1;
                    reg_b <= reg_b >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // The final carry is the one produced by
                        // this last step, not the stale register.
                        bus.COUT <= fa_cout;
                        bus.DONE <= 1'b1;
                        state    <= FINISH;
                    end
                end
                FINISH: begin
                    bus.DONE <= 1'b0;
                    bus.BUSY <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
